// File: rtl/hdmi_qsys_pio_pkg.sv
// Shared register map, bit indices and byte-lane helper for the HDMI PIO bank.
package hdmi_qsys_pio_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_SET    = 2'd1;
  localparam logic [1:0] OFF_CLR    = 2'd2;
  localparam logic [1:0] OFF_ACTIVE = 2'd3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int CTRL_COMMIT    = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_PENDING = 0;
  localparam int STATUS_IRQ     = 1;

  // Encoded to match the word offsets, so a write to ACTIVE decodes to OP_NONE.
  typedef enum logic [1:0] {
    OP_DATA = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_NONE = 2'd3
  } chan_op_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be, input int width);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = be[i / 8] & (i < width);
    end
    return m;
  endfunction

endpackage

// File: rtl/hdmi_qsys_pio_chan.sv
// One channel of the PIO bank: CPU-visible shadow register plus the active
// register that only follows the shadow on a bank-wide commit.
module hdmi_qsys_pio_chan
  import hdmi_qsys_pio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] mask_i,
  input  logic              commit_i,
  output logic [DATA_W-1:0] shadow_o,
  output logic [DATA_W-1:0] active_o
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    unique case (chan_op_e'(op_i))
      OP_DATA: shadow_d = (shadow_q & ~mask_i) | (wdata_i & mask_i);
      OP_SET:  shadow_d = shadow_q | (wdata_i & mask_i);
      OP_CLR:  shadow_d = shadow_q & ~(wdata_i & mask_i);
      default: shadow_d = shadow_q;
    endcase
    // Commit samples the pre-write shadow, so a racing CPU write waits for the next commit.
    active_d = commit_i ? shadow_q : active_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= RESET_VAL;
      active_q <= RESET_VAL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/hdmi_qsys_pio_bank.sv
// Avalon-MM bank of frame-synchronous control words for the HDMI pipeline.
// Optional commit-done interrupt is built when HDMI_PIO_IRQ_EN is defined.
module hdmi_qsys_pio_bank
  import hdmi_qsys_pio_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(4*NUM_CH+4)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [3:0]               byteenable,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] out_port
`ifdef HDMI_PIO_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] GLB_IDX = IDX_W'(NUM_CH);

  logic              wr;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic [31:0]       mask_full;
  logic [DATA_W-1:0] mask_w;
  logic [DATA_W-1:0] wdata_w;
  logic              shadow_wr;
  logic              ctrl_wr;
  logic              commit;
  logic              fs_edge;

  logic fs_q;
  logic pending_q, pending_d;
  logic auto_q, auto_d;
  logic irq_en_w, irq_w;

  logic [NUM_CH-1:0][1:0]        op_w;
  logic [NUM_CH-1:0][DATA_W-1:0] shadow_w;
  logic [NUM_CH-1:0][DATA_W-1:0] active_w;
  logic [31:0]                   rd;

  assign wr        = chipselect & ~write_n;
  assign idx       = address[ADDR_W-1:2];
  assign off       = address[1:0];
  assign mask_full = be_mask(byteenable, DATA_W);
  assign mask_w    = mask_full[DATA_W-1:0];
  assign wdata_w   = writedata[DATA_W-1:0];

  assign shadow_wr = wr && (idx < GLB_IDX) && (off != OFF_ACTIVE);
  assign ctrl_wr   = wr && (idx == GLB_IDX) && (off == OFF_CTRL) && byteenable[0];
  assign fs_edge   = frame_sync & ~fs_q;
  assign commit    = (ctrl_wr && writedata[CTRL_COMMIT]) || (auto_q && pending_q && fs_edge);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign op_w[c] = (wr && idx == IDX_W'(c)) ? off : OP_NONE;

    hdmi_qsys_pio_chan #(
      .DATA_W   (DATA_W),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .op_i    (op_w[c]),
      .wdata_i (wdata_w),
      .mask_i  (mask_w),
      .commit_i(commit),
      .shadow_o(shadow_w[c]),
      .active_o(active_w[c])
    );

    assign out_port[c*DATA_W +: DATA_W] = active_w[c];
  end

  always_comb begin
    pending_d = pending_q;
    if (commit)    pending_d = 1'b0;
    if (shadow_wr) pending_d = 1'b1;
    auto_d = ctrl_wr ? writedata[CTRL_AUTO] : auto_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs_q      <= 1'b0;
      pending_q <= 1'b0;
      auto_q    <= 1'b0;
    end else begin
      fs_q      <= frame_sync;
      pending_q <= pending_d;
      auto_q    <= auto_d;
    end
  end

`ifdef HDMI_PIO_IRQ_EN
  logic status_wr;
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  assign status_wr = wr && (idx == GLB_IDX) && (off == OFF_STATUS) && byteenable[0];

  always_comb begin
    irq_en_d = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;
    irq_d    = irq_q;
    if (status_wr && writedata[STATUS_IRQ]) irq_d = 1'b0;
    if (commit && irq_en_q)                 irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq      = irq_q;
  assign irq_en_w = irq_en_q;
  assign irq_w    = irq_q;
`else
  assign irq_en_w = 1'b0;
  assign irq_w    = 1'b0;
`endif

  always_comb begin
    rd = '0;
    if (idx < GLB_IDX) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (idx == IDX_W'(c)) begin
          rd = 32'((off == OFF_ACTIVE) ? active_w[c] : shadow_w[c]);
        end
      end
    end else if (idx == GLB_IDX) begin
      case (off)
        OFF_CTRL: begin
          rd[CTRL_AUTO]   = auto_q;
          rd[CTRL_IRQ_EN] = irq_en_w;
        end
        OFF_STATUS: begin
          rd[STATUS_PENDING] = pending_q;
          rd[STATUS_IRQ]     = irq_w;
        end
        default: rd = '0;
      endcase
    end
  end

  assign readdata = rd;

endmodule

// File: tb/tb_hdmi_qsys_pio_bank.sv
// Directed bench for hdmi_qsys_pio_bank (4 channels x 32 bits, reset value 0xFF).
module tb_hdmi_qsys_pio_bank;

  localparam logic [31:0] RV = 32'h0000_00FF;
  localparam logic [4:0] A_CTRL   = 5'd16;
  localparam logic [4:0] A_STATUS = 5'd17;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [4:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [3:0]   byteenable;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         frame_sync;
  logic [127:0] out_port;
`ifdef HDMI_PIO_IRQ_EN
  logic         irq;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hdmi_qsys_pio_bank #(
    .NUM_CH   (4),
    .DATA_W   (32),
    .RESET_VAL(RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .byteenable(byteenable),
    .writedata (writedata),
    .readdata  (readdata),
    .frame_sync(frame_sync),
    .out_port  (out_port)
`ifdef HDMI_PIO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  function automatic logic [31:0] ch_out(input int c);
    return out_port[c*32 +: 32];
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address = a; writedata = d; byteenable = be;
    chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [4:0] unmapped [4];
    unmapped = '{5'd18, 5'd19, 5'd20, 5'd31};
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    byteenable = 4'h0; writedata = '0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (out_port !== {4{RV}}) begin
      mismatched++; $display("FAIL reset_out_port: got %h want %h", out_port, {4{RV}});
    end
    for (int c = 0; c < 4; c++) begin
      bus_read(5'(4*c), r);
      compared++;
      if (r !== RV) begin
        mismatched++; $display("FAIL reset_data ch%0d: got %h want %h", c, r, RV);
      end
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL reset_status: got %h want 0", r);
    end
    bus_read(A_CTRL, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL reset_ctrl: got %h want 0", r);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(unmapped[i], r);
      compared++;
      if (r !== 32'h0) begin
        mismatched++; $display("FAIL unmapped_read a=%0d: got %h want 0", unmapped[i], r);
      end
    end
  endtask

  task automatic test_data_commit();
    logic [31:0] r;
    bus_write(5'd4, 32'hDEAD_BEEF, 4'b0011);
    bus_read(5'd4, r);
    compared++;
    if (r !== 32'h0000_BEEF) begin
      mismatched++; $display("FAIL data_be_shadow: got %h want 0000beef", r);
    end
    compared++;
    if (ch_out(1) !== RV) begin
      mismatched++; $display("FAIL data_no_commit_out: got %h want %h", ch_out(1), RV);
    end
    bus_read(5'd7, r);
    compared++;
    if (r !== RV) begin
      mismatched++; $display("FAIL data_active_read: got %h want %h", r, RV);
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h1) begin
      mismatched++; $display("FAIL data_pending: got %h want 1", r);
    end
    bus_write(A_CTRL, 32'h1, 4'hF);
    compared++;
    if (ch_out(1) !== 32'h0000_BEEF) begin
      mismatched++; $display("FAIL commit_out ch1: got %h want 0000beef", ch_out(1));
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL commit_pending_clr: got %h want 0", r);
    end
    bus_read(A_CTRL, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL commit_self_clear: got %h want 0", r);
    end
  endtask

  task automatic test_auto_frame();
    logic [31:0] r;
    bus_write(A_CTRL, 32'h2, 4'hF);
    bus_write(5'd0, 32'h0, 4'hF);
    bus_write(5'd1, 32'h0F, 4'hF);
    bus_write(5'd2, 32'h03, 4'hF);
    bus_read(5'd0, r);
    compared++;
    if (r !== 32'h0C) begin
      mismatched++; $display("FAIL set_clr_shadow: got %h want 0000000c", r);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) frame_sync = 1'b1;
    #1;
    compared++;
    if (ch_out(0) !== RV) begin
      mismatched++; $display("FAIL auto_before_edge: got %h want %h", ch_out(0), RV);
    end
    @(posedge clk); #1;
    compared++;
    if (ch_out(0) !== 32'h0C) begin
      mismatched++; $display("FAIL auto_after_edge: got %h want 0000000c", ch_out(0));
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL auto_pending_clr: got %h want 0", r);
    end
    bus_write(5'd0, 32'h55, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (ch_out(0) !== 32'h0C) begin
      mismatched++; $display("FAIL held_level_no_commit: got %h want 0000000c", ch_out(0));
    end
    @(negedge clk) frame_sync = 1'b0;
    @(negedge clk) frame_sync = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (ch_out(0) !== 32'h55) begin
      mismatched++; $display("FAIL second_edge_commit: got %h want 00000055", ch_out(0));
    end
    @(negedge clk) frame_sync = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [31:0] r;
    bus_write(5'd8, 32'h1111, 4'hF);
    @(negedge clk);
    address = 5'd8; writedata = 32'h2222; byteenable = 4'hF;
    chipselect = 1'b1; write_n = 1'b0; frame_sync = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    compared++;
    if (ch_out(2) !== 32'h1111) begin
      mismatched++; $display("FAIL race_active_old: got %h want 00001111", ch_out(2));
    end
    bus_read(5'd8, r);
    compared++;
    if (r !== 32'h2222) begin
      mismatched++; $display("FAIL race_shadow_new: got %h want 00002222", r);
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h1) begin
      mismatched++; $display("FAIL race_pending_kept: got %h want 1", r);
    end
    @(negedge clk) frame_sync = 1'b0;
    @(negedge clk) frame_sync = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (ch_out(2) !== 32'h2222) begin
      mismatched++; $display("FAIL race_next_edge: got %h want 00002222", ch_out(2));
    end
    @(negedge clk) frame_sync = 1'b0;
  endtask

  task automatic test_auto_off();
    logic [31:0] r;
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(5'd14, 32'hF0, 4'b0001);
    bus_write(5'd13, 32'hAB00_0000, 4'b1000);
    bus_read(5'd12, r);
    compared++;
    if (r !== 32'hAB00_000F) begin
      mismatched++; $display("FAIL be_set_clr ch3: got %h want ab00000f", r);
    end
    @(negedge clk) frame_sync = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) frame_sync = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (ch_out(3) !== RV) begin
      mismatched++; $display("FAIL auto_off_out: got %h want %h", ch_out(3), RV);
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h1) begin
      mismatched++; $display("FAIL auto_off_pending: got %h want 1", r);
    end
    bus_write(A_CTRL, 32'h1, 4'hF);
    compared++;
    if (ch_out(3) !== 32'hAB00_000F) begin
      mismatched++; $display("FAIL manual_commit ch3: got %h want ab00000f", ch_out(3));
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    bus_write(5'd3, 32'h1234_5678, 4'hF);
    bus_write(5'd18, 32'hFFFF_FFFF, 4'hF);
    bus_write(5'd20, 32'hFFFF_FFFF, 4'hF);
    bus_write(5'd31, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    address = 5'd0; writedata = 32'hAAAA; byteenable = 4'hF;
    chipselect = 1'b0; write_n = 1'b0;
    @(posedge clk); #1;
    write_n = 1'b1;
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL ignored_writes_pending: got %h want 0", r);
    end
    bus_read(A_CTRL, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL ignored_writes_ctrl: got %h want 0", r);
    end
    bus_read(5'd0, r);
    compared++;
    if (r !== 32'h55) begin
      mismatched++; $display("FAIL ignored_writes_shadow: got %h want 00000055", r);
    end
    compared++;
    if (ch_out(0) !== 32'h55) begin
      mismatched++; $display("FAIL active_write_ignored: got %h want 00000055", ch_out(0));
    end
  endtask

  task automatic test_irq();
    logic [31:0] r;
`ifdef HDMI_PIO_IRQ_EN
    bus_write(A_CTRL, 32'h4, 4'hF);
    bus_read(A_CTRL, r);
    compared++;
    if (r !== 32'h4) begin
      mismatched++; $display("FAIL irq_en_read: got %h want 4", r);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL irq_idle: got %b want 0", irq);
    end
    bus_write(A_CTRL, 32'h5, 4'hF);
    compared++;
    if (irq !== 1'b1) begin
      mismatched++; $display("FAIL irq_after_commit: got %b want 1", irq);
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h2) begin
      mismatched++; $display("FAIL irq_status: got %h want 2", r);
    end
    bus_write(A_STATUS, 32'h2, 4'hF);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL irq_w1c: got %b want 0", irq);
    end
    bus_write(A_CTRL, 32'h5, 4'hF);
`else
    bus_write(A_CTRL, 32'h4, 4'hF);
    bus_read(A_CTRL, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL no_irq_ctrl_bit2: got %h want 0", r);
    end
    bus_write(A_CTRL, 32'h5, 4'hF);
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin
      mismatched++; $display("FAIL no_irq_status_bit1: got %h want 0", r);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    bus_write(5'd4, 32'h77, 4'hF);
    @(negedge clk);
    address = A_STATUS;
    #2 reset_n = 1'b0;
    #1;
    compared++;
    if (out_port !== {4{RV}}) begin
      mismatched++; $display("FAIL async_reset_out: got %h want %h", out_port, {4{RV}});
    end
    compared++;
    if (readdata !== 32'h0) begin
      mismatched++; $display("FAIL async_reset_status: got %h want 0", readdata);
    end
`ifdef HDMI_PIO_IRQ_EN
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL async_reset_irq: got %b want 0", irq);
    end
`endif
    bus_read(5'd4, r);
    compared++;
    if (r !== RV) begin
      mismatched++; $display("FAIL async_reset_shadow: got %h want %h", r, RV);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_data_commit();
    test_auto_frame();
    test_same_cycle();
    test_auto_off();
    test_unmapped();
    test_irq();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
